iob_clint_arbiter: RTL and testbench
====================================

// Module: iob_clint_arbiter
// PURPOSE
//  Round-robin arbiter that shares the single IOb slave port of the CLINT among N_REQ IOb
//  managers (cores, debug module). One transaction is in flight at a time; the grant is
//  held until that transaction completes. Sits between the core-side buses and the CLINT.
// PARAMETERS
//  N_REQ      2   number of requesting managers (>=2)
//  ADDR_W     16  IOb address width
//  DATA_W     32  IOb data width; wstrb width is DATA_W/8
//  TIMEOUT_W  8   timeout counter width; used only with the optional feature
// PORTS
//  clk_i       in   1               clock
//  cke_i       in   1               clock enable; when 0 all state holds
//  rst_i       in   1               reset
//  m_avalid_i  in   N_REQ           per-manager request valid
//  m_addr_i    in   N_REQ*ADDR_W    per-manager address, manager k in slice k
//  m_wdata_i   in   N_REQ*DATA_W    per-manager write data
//  m_wstrb_i   in   N_REQ*DATA_W/8  per-manager strobes; nonzero = write, zero = read
//  m_ready_o   out  N_REQ           per-manager accept
//  m_rvalid_o  out  N_REQ           per-manager read data valid
//  m_rdata_o   out  DATA_W          read data, shared by all managers
//  s_avalid_o  out  1               to CLINT
//  s_addr_o    out  ADDR_W          to CLINT
//  s_wdata_o   out  DATA_W          to CLINT
//  s_wstrb_o   out  DATA_W/8        to CLINT
//  s_ready_i   in   1               from CLINT
//  s_rvalid_i  in   1               from CLINT
//  s_rdata_i   in   DATA_W          from CLINT
//  gnt_o       out  N_REQ           one-hot current grant; all zero in IDLE
//  err_o       out  1               one-cycle timeout pulse
// BEHAVIOUR
//  - Interface: one clock, clk_i. Reset rst_i is synchronous and active-high.
//  - Reset: state=IDLE, gnt_o=0, ptr=0 (manager 0 has top priority), timer=0, all outputs 0.
//    Reset asserted mid-transaction aborts it with no response to the manager. A CLINT
//    rvalid arriving after reset (in IDLE) is dropped.
//  - Managers hold avalid/addr/wdata/wstrb stable until their m_ready_o.
//  - FSM, one transaction per grant:
//    IDLE: if any m_avalid_i, register grant to the first asserted index at or after ptr,
//      searching upward and wrapping past N_REQ-1 to 0. Next state is ACCESS.
//      Otherwise stay in IDLE.
//    ACCESS: s_* = muxed fields of granted manager k; s_avalid_o=m_avalid_i[k];
//      m_ready_o[k]=s_ready_i. On s_avalid_o & s_ready_i: write -> IDLE; read -> RESP.
//      If m_avalid_i[k] drops before acceptance -> IDLE with no response.
//    RESP: s_avalid_o=0. On s_rvalid_i: m_rvalid_o[k]=1 and m_rdata_o=s_rdata_i, both
//      combinational from the CLINT. Next state is IDLE.
//    Every exit to IDLE sets ptr=(k+1) mod N_REQ.
//  - Latency with CLINT ready=1: write 2 cycles (IDLE+ACCESS); read 3 cycles plus CLINT
//    rvalid latency.
//  - m_ready_o and m_rvalid_o are 0 for non-granted managers. m_rdata_o=0 when no
//    m_rvalid_o is asserted.
//  - Fairness: a continuously requesting manager waits at most N_REQ-1 transactions.
// CONFIGURATION
//  IOB_CLINT_ARB_TIMEOUT_EN defined:
//  - An up-counter runs in ACCESS and RESP and clears on entry to IDLE.
//  - If it reaches 2**TIMEOUT_W-1 before completion, then in that cycle:
//    - ACCESS: m_ready_o[k]=1. For a read, also m_rvalid_o[k]=1 with m_rdata_o={DATA_W{1'b1}}.
//    - RESP: m_rvalid_o[k]=1 with m_rdata_o={DATA_W{1'b1}}.
//    - err_o=1 for that one cycle, and the FSM goes to IDLE with ptr rotated.
//  - Completion in the same cycle as expiry counts as completion: no error, real data returned.
//  Not defined: no counter, err_o tied 0, the FSM waits indefinitely.
// TESTING
//  1 Single read: m1 reads 0xBFF8 while CLINT returns 0x1234 -> s_addr_o=0xBFF8 in cycle 1,
//    m_rvalid_o=2'b10 and m_rdata_o=0x1234 when s_rvalid_i is high. m0 outputs stay 0.
//  2 Contention: m0 and m1 both write continuously, ptr=0 -> grants alternate 0,1,0,1.
//    Every write takes 2 cycles and none is lost.
//  3 Wrap: N_REQ=4, last grant 3, m0 and m2 request -> m0 is granted before m2.
//  4 Reset in RESP: assert rst_i, then pulse s_rvalid_i -> no m_rvalid_o, gnt_o=0, next grant
//    goes to m0.
//  5 Timeout (macro on, TIMEOUT_W=4): read with s_rvalid_i never asserted -> after 15 cycles in
//    ACCESS+RESP, m_rvalid_o set, m_rdata_o=0xFFFFFFFF, err_o pulses once, FSM back to IDLE.
//  6 Withdrawn request: m0 drops avalid in ACCESS while s_ready_i=0 -> IDLE, no m_ready_o,
//    ptr=1.

Source files
------------

// File: rtl/iob_clint_arbiter.sv
// Round-robin arbiter sharing the CLINT IOb slave port among N_REQ managers, one transaction per grant.
// Optional access timeout is enabled by defining IOB_CLINT_ARB_TIMEOUT_EN.
module iob_clint_arbiter #(
  parameter int N_REQ     = 2,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 32,
  parameter int TIMEOUT_W = 8
) (
  input  logic                          clk_i,
  input  logic                          cke_i,
  input  logic                          rst_i,
  input  logic [N_REQ-1:0]              m_avalid_i,
  input  logic [N_REQ*ADDR_W-1:0]       m_addr_i,
  input  logic [N_REQ*DATA_W-1:0]       m_wdata_i,
  input  logic [N_REQ*(DATA_W/8)-1:0]   m_wstrb_i,
  output logic [N_REQ-1:0]              m_ready_o,
  output logic [N_REQ-1:0]              m_rvalid_o,
  output logic [DATA_W-1:0]             m_rdata_o,
  output logic                          s_avalid_o,
  output logic [ADDR_W-1:0]             s_addr_o,
  output logic [DATA_W-1:0]             s_wdata_o,
  output logic [DATA_W/8-1:0]           s_wstrb_o,
  input  logic                          s_ready_i,
  input  logic                          s_rvalid_i,
  input  logic [DATA_W-1:0]             s_rdata_i,
  output logic [N_REQ-1:0]              gnt_o,
  output logic                          err_o
);

  localparam int STRB_W = DATA_W / 8;
  localparam int IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_inc;
  logic             expired;

  logic              k_avalid;
  logic              k_write;
  logic [ADDR_W-1:0] k_addr;
  logic [DATA_W-1:0] k_wdata;
  logic [STRB_W-1:0] k_wstrb;

  // First requester at or after start, wrapping past N_REQ-1 back to 0.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                               input logic [IDX_W-1:0] start);
    logic [IDX_W-1:0] sel;
    logic             found;
    int               j;
    sel   = start;
    found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      j = int'(start) + i;
      if (j >= N_REQ) j = j - N_REQ;
      if (!found && req[j]) begin
        sel   = IDX_W'(j);
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  assign k_avalid = m_avalid_i[idx];
  assign k_addr   = m_addr_i[idx*ADDR_W +: ADDR_W];
  assign k_wdata  = m_wdata_i[idx*DATA_W +: DATA_W];
  assign k_wstrb  = m_wstrb_i[idx*STRB_W +: STRB_W];
  assign k_write  = |k_wstrb;
  assign idx_inc  = (int'(idx) == N_REQ - 1) ? '0 : idx + 1'b1;
  assign gnt_o    = (state == IDLE) ? '0 : (N_REQ'(1) << idx);

  always_comb begin
    state_nxt  = state;
    m_ready_o  = '0;
    m_rvalid_o = '0;
    m_rdata_o  = '0;
    s_avalid_o = 1'b0;
    s_addr_o   = '0;
    s_wdata_o  = '0;
    s_wstrb_o  = '0;
    err_o      = 1'b0;
    case (state)
      IDLE: begin
        if (|m_avalid_i) state_nxt = ACCESS;
      end
      ACCESS: begin
        s_avalid_o     = k_avalid;
        s_addr_o       = k_addr;
        s_wdata_o      = k_wdata;
        s_wstrb_o      = k_wstrb;
        m_ready_o[idx] = s_ready_i;
        if (k_avalid && s_ready_i) begin
          state_nxt = k_write ? IDLE : RESP;
        end else if (!k_avalid) begin
          state_nxt = IDLE;
        end else if (expired) begin
          m_ready_o[idx] = 1'b1;
          if (!k_write) begin
            m_rvalid_o[idx] = 1'b1;
            m_rdata_o       = '1;
          end
          err_o     = 1'b1;
          state_nxt = IDLE;
        end
      end
      RESP: begin
        if (s_rvalid_i) begin
          m_rvalid_o[idx] = 1'b1;
          m_rdata_o       = s_rdata_i;
          state_nxt       = IDLE;
        end else if (expired) begin
          m_rvalid_o[idx] = 1'b1;
          m_rdata_o       = '1;
          err_o           = 1'b1;
          state_nxt       = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      ptr   <= '0;
      idx   <= '0;
    end else if (cke_i) begin
      state <= state_nxt;
      if (state == IDLE) idx <= rr_pick(m_avalid_i, ptr);
      if (state != IDLE && state_nxt == IDLE) ptr <= idx_inc;
    end
  end

`ifdef IOB_CLINT_ARB_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] timer;

  // Counts cycles spent with a grant held; zero on the first ACCESS cycle.
  assign expired = (state != IDLE) && (timer == '1);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      timer <= '0;
    end else if (cke_i) begin
      if (state == IDLE || state_nxt == IDLE) timer <= '0;
      else                                    timer <= timer + 1'b1;
    end
  end
`else
  logic [TIMEOUT_W-1:0] unused_timer;

  assign unused_timer = '0;
  assign expired      = 1'b0;
`endif

endmodule

// File: tb/tb_iob_clint_arbiter.sv
// Bench for iob_clint_arbiter: directed corner cases, then randomized traffic checked by a scoreboard.
module tb_iob_clint_arbiter;
  localparam int N  = 4;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TW = 4;

  logic            clk;
  logic            cke_i;
  logic            rst_i;
  logic [N-1:0]    m_avalid_i;
  logic [N*AW-1:0] m_addr_i;
  logic [N*DW-1:0] m_wdata_i;
  logic [N*SW-1:0] m_wstrb_i;
  logic [N-1:0]    m_ready_o;
  logic [N-1:0]    m_rvalid_o;
  logic [DW-1:0]   m_rdata_o;
  logic            s_avalid_o;
  logic [AW-1:0]   s_addr_o;
  logic [DW-1:0]   s_wdata_o;
  logic [SW-1:0]   s_wstrb_o;
  logic            s_ready_i;
  logic            s_rvalid_i;
  logic [DW-1:0]   s_rdata_i;
  logic [N-1:0]    gnt_o;
  logic            err_o;

  iob_clint_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_W(TW)) dut (
    .clk_i(clk), .cke_i(cke_i), .rst_i(rst_i),
    .m_avalid_i(m_avalid_i), .m_addr_i(m_addr_i), .m_wdata_i(m_wdata_i), .m_wstrb_i(m_wstrb_i),
    .m_ready_o(m_ready_o), .m_rvalid_o(m_rvalid_o), .m_rdata_o(m_rdata_o),
    .s_avalid_o(s_avalid_o), .s_addr_o(s_addr_o), .s_wdata_o(s_wdata_o), .s_wstrb_o(s_wstrb_o),
    .s_ready_i(s_ready_i), .s_rvalid_i(s_rvalid_i), .s_rdata_i(s_rdata_i),
    .gnt_o(gnt_o), .err_o(err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
  } tx_t;

  typedef struct packed {
    logic [1:0]    k;
    logic [DW-1:0] data;
  } resp_t;

  int     errors = 0;
  int     checks = 0;
  logic   mon_en = 1'b0;
  tx_t    exp_req [N][$];
  resp_t  resp_q [$];
  logic [N-1:0] acc_flag = '0;
  logic   rd_pending = 1'b0;
  int     rd_k = 0;
  int     rd_delay = 0;
  int     m_busy = 0;
  int     m_k = 0;
  int     ptr_m = 0;
  int     waits [N];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic set_req(input int k, input logic v, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [SW-1:0] s);
    m_avalid_i[k]          = v;
    m_addr_i[k*AW +: AW]   = a;
    m_wdata_i[k*DW +: DW]  = d;
    m_wstrb_i[k*SW +: SW]  = s;
  endtask

  // Round-robin rule: first requester at or after start, wrapping.
  function automatic int rr(input logic [N-1:0] req, input int start);
    for (int i = 0; i < N; i++)
      if (req[(start + i) % N]) return (start + i) % N;
    return start;
  endfunction

  // Scoreboard monitor: transaction-level model of grant/ownership, checks DUT each negedge.
  always @(negedge clk) begin
    if (mon_en) begin
      logic [N-1:0] eg;
      logic [N-1:0] erv;
      tx_t          t;
      resp_t        r;
      eg = '0;
      if (m_busy != 0) eg[m_k] = 1'b1;
      erv = (m_busy == 2 && s_rvalid_i) ? eg : '0;
      chk("gnt", 64'(gnt_o), 64'(eg));
      chk("err_idle", 64'(err_o), 64'(0));
      chk("rvalid_when", 64'(m_rvalid_o), 64'(erv));
      acc_flag = acc_flag | (m_ready_o & m_avalid_i);
      case (m_busy)
        0: begin
          chk("idle_savalid", 64'(s_avalid_o), 64'(0));
          chk("idle_ready", 64'(m_ready_o), 64'(0));
          if (|m_avalid_i) begin
            m_k = rr(m_avalid_i, ptr_m);
            chk("fair_wait", 64'(waits[m_k] <= N - 1), 64'(1));
            for (int k = 0; k < N; k++)
              if (k != m_k && m_avalid_i[k]) waits[k]++;
            waits[m_k] = 0;
            m_busy = 1;
          end
        end
        1: begin
          chk("acc_savalid", 64'(s_avalid_o), 64'(1));
          chk("acc_ready", 64'(m_ready_o), 64'(s_ready_i ? eg : '0));
          if (s_ready_i) begin
            chk("req_pending", 64'(exp_req[m_k].size() != 0), 64'(1));
            if (exp_req[m_k].size() != 0) begin
              t = exp_req[m_k].pop_front();
              chk("s_addr", 64'(s_addr_o), 64'(t.addr));
              chk("s_wdata", 64'(s_wdata_o), 64'(t.wdata));
              chk("s_wstrb", 64'(s_wstrb_o), 64'(t.wstrb));
              if (t.wstrb == '0) begin
                m_busy     = 2;
                rd_pending = 1'b1;
                rd_k       = m_k;
                rd_delay   = $urandom_range(0, 3);
              end else begin
                m_busy = 0;
                ptr_m  = (m_k + 1) % N;
              end
            end
          end
        end
        default: begin
          chk("resp_savalid", 64'(s_avalid_o), 64'(0));
          chk("resp_ready", 64'(m_ready_o), 64'(0));
          if (s_rvalid_i) begin
            m_busy = 0;
            ptr_m  = (m_k + 1) % N;
          end
        end
      endcase
      if (m_rvalid_o != '0) begin
        chk("resp_pending", 64'(resp_q.size() != 0), 64'(1));
        if (resp_q.size() != 0) begin
          r = resp_q.pop_front();
          chk("rvalid_owner", 64'(m_rvalid_o), 64'(N'(1) << r.k));
          chk("rdata", 64'(m_rdata_o), 64'(r.data));
        end
      end else begin
        chk("rdata_zero", 64'(m_rdata_o), 64'(0));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1);
  end

  initial begin
    tx_t   t;
    resp_t r;
    for (int k = 0; k < N; k++) waits[k] = 0;
    cke_i = 1'b1; rst_i = 1'b1;
    m_avalid_i = '0; m_addr_i = '0; m_wdata_i = '0; m_wstrb_i = '0;
    s_ready_i = 1'b0; s_rvalid_i = 1'b0; s_rdata_i = 32'hDEAD_BEEF;
    step(); step(); settle();
    chk("rst_gnt", 64'(gnt_o), 64'(0));
    chk("rst_ready", 64'(m_ready_o), 64'(0));
    chk("rst_rvalid", 64'(m_rvalid_o), 64'(0));
    chk("rst_rdata", 64'(m_rdata_o), 64'(0));
    chk("rst_savalid", 64'(s_avalid_o), 64'(0));
    chk("rst_saddr", 64'(s_addr_o), 64'(0));
    chk("rst_err", 64'(err_o), 64'(0));
    rst_i = 1'b0;

    // Single read by m1
    set_req(1, 1'b1, 16'hBFF8, '0, '0); s_ready_i = 1'b1; settle();
    chk("t1_idle_gnt", 64'(gnt_o), 64'(0));
    step(); settle();
    chk("t1_gnt", 64'(gnt_o), 64'(4'b0010));
    chk("t1_savalid", 64'(s_avalid_o), 64'(1));
    chk("t1_saddr", 64'(s_addr_o), 64'(16'hBFF8));
    chk("t1_ready", 64'(m_ready_o), 64'(4'b0010));
    step(); set_req(1, 1'b0, '0, '0, '0);
    s_rvalid_i = 1'b1; s_rdata_i = 32'h1234; settle();
    chk("t1_rvalid", 64'(m_rvalid_o), 64'(4'b0010));
    chk("t1_rdata", 64'(m_rdata_o), 64'(32'h1234));
    chk("t1_resp_ready", 64'(m_ready_o), 64'(0));
    chk("t1_resp_savalid", 64'(s_avalid_o), 64'(0));
    step(); s_rvalid_i = 1'b0; s_rdata_i = 32'hDEAD_BEEF; settle();
    chk("t1_done_gnt", 64'(gnt_o), 64'(0));
    chk("t1_done_rvalid", 64'(m_rvalid_o), 64'(0));
    chk("t1_done_rdata", 64'(m_rdata_o), 64'(0));

    // Wrap: m3 granted, then m0 beats m2
    set_req(3, 1'b1, 16'h0030, 32'hA3, 4'hF); settle();
    step(); settle();
    chk("t3_gnt3", 64'(gnt_o), 64'(4'b1000));
    chk("t3_ready3", 64'(m_ready_o), 64'(4'b1000));
    step(); set_req(3, 1'b0, '0, '0, '0);
    set_req(0, 1'b1, 16'h0100, 32'hA0, 4'h1);
    set_req(2, 1'b1, 16'h0120, 32'hA2, 4'h3); settle();
    chk("t3_wr_2cyc", 64'(gnt_o), 64'(0));
    step(); settle();
    chk("t3_gnt0", 64'(gnt_o), 64'(4'b0001));
    chk("t3_saddr0", 64'(s_addr_o), 64'(16'h0100));
    chk("t3_swdata0", 64'(s_wdata_o), 64'(32'hA0));
    step(); set_req(0, 1'b0, '0, '0, '0); settle();
    step(); settle();
    chk("t3_gnt2", 64'(gnt_o), 64'(4'b0100));
    chk("t3_swstrb2", 64'(s_wstrb_o), 64'(4'h3));
    step(); set_req(2, 1'b0, '0, '0, '0); settle();

    // Reset during RESP
    set_req(0, 1'b1, 16'h0200, '0, '0); settle();
    step(); settle();
    chk("t4_gnt0", 64'(gnt_o), 64'(4'b0001));
    step(); set_req(0, 1'b0, '0, '0, '0); rst_i = 1'b1; settle();
    step(); rst_i = 1'b0; s_rvalid_i = 1'b1; s_rdata_i = 32'h5555; settle();
    chk("t4_no_rvalid", 64'(m_rvalid_o), 64'(0));
    chk("t4_rdata", 64'(m_rdata_o), 64'(0));
    chk("t4_gnt", 64'(gnt_o), 64'(0));
    step(); s_rvalid_i = 1'b0;
    set_req(0, 1'b1, 16'h0210, 32'hB0, 4'hF);
    set_req(1, 1'b1, 16'h0214, 32'hB1, 4'hF); settle();
    step(); settle();
    chk("t4_next_gnt0", 64'(gnt_o), 64'(4'b0001));
    step(); set_req(0, 1'b0, '0, '0, '0); settle();
    step(); settle();
    chk("t4_gnt1", 64'(gnt_o), 64'(4'b0010));
    step(); set_req(1, 1'b0, '0, '0, '0); settle();

    // Withdrawn request
    s_ready_i = 1'b0; set_req(0, 1'b1, 16'h0300, '0, '0); settle();
    step(); settle();
    chk("t6_gnt0", 64'(gnt_o), 64'(4'b0001));
    chk("t6_no_ready", 64'(m_ready_o), 64'(0));
    step(); set_req(0, 1'b0, '0, '0, '0); settle();
    chk("t6_drop_ready", 64'(m_ready_o), 64'(0));
    chk("t6_drop_savalid", 64'(s_avalid_o), 64'(0));
    step(); settle();
    chk("t6_idle", 64'(gnt_o), 64'(0));
    s_ready_i = 1'b1;
    set_req(0, 1'b1, 16'h0310, 32'hC0, 4'hF);
    set_req(1, 1'b1, 16'h0314, 32'hC1, 4'hF);
    step(); settle();
    chk("t6_ptr1", 64'(gnt_o), 64'(4'b0010));
    step(); set_req(1, 1'b0, '0, '0, '0); settle();
    step(); settle();
    chk("t6_then0", 64'(gnt_o), 64'(4'b0001));
    step(); set_req(0, 1'b0, '0, '0, '0); settle();

`ifdef IOB_CLINT_ARB_TIMEOUT_EN
    // Read that the CLINT never answers expires on the 16th granted cycle
    set_req(1, 1'b1, 16'hBFF8, '0, '0); s_ready_i = 1'b1;
    step(); settle();
    chk("t5_gnt", 64'(gnt_o), 64'(4'b0010));
    step(); set_req(1, 1'b0, '0, '0, '0);
    for (int c = 1; c < 15; c++) begin
      settle();
      chk("t5_err_early", 64'(err_o), 64'(0));
      chk("t5_rvalid_early", 64'(m_rvalid_o), 64'(0));
      step();
    end
    settle();
    chk("t5_rvalid", 64'(m_rvalid_o), 64'(4'b0010));
    chk("t5_rdata", 64'(m_rdata_o), 64'(32'hFFFF_FFFF));
    chk("t5_err", 64'(err_o), 64'(1));
    step(); settle();
    chk("t5_err_once", 64'(err_o), 64'(0));
    chk("t5_idle", 64'(gnt_o), 64'(0));
`endif

    // Randomized traffic: contention burst on m0/m1 first, then mixed reads/writes
    rst_i = 1'b1; step(); rst_i = 1'b0;
    m_busy = 0; ptr_m = 0; acc_flag = '0; rd_pending = 1'b0;
    mon_en = 1'b1;
    for (int cyc = 0; cyc < 2600; cyc++) begin
      @(posedge clk); #1;
      for (int k = 0; k < N; k++)
        if (acc_flag[k]) begin
          acc_flag[k] = 1'b0;
          m_avalid_i[k] = 1'b0;
        end
      for (int k = 0; k < N; k++) begin
        if (!m_avalid_i[k] && cyc < 2400 &&
            ((cyc < 200) ? (k < 2) : ($urandom_range(0, 3) == 0))) begin
          t.addr  = AW'($urandom);
          t.wdata = $urandom;
          if (cyc < 200 || $urandom_range(0, 1) == 1) t.wstrb = SW'($urandom_range(1, 15));
          else                                       t.wstrb = '0;
          set_req(k, 1'b1, t.addr, t.wdata, t.wstrb);
          exp_req[k].push_back(t);
        end
      end
      s_ready_i  = (cyc < 200) || (cyc >= 2400) || ($urandom_range(0, 9) < 7);
      s_rvalid_i = 1'b0;
      s_rdata_i  = $urandom;
      if (rd_pending) begin
        if (rd_delay == 0) begin
          s_rvalid_i = 1'b1;
          r.k        = 2'(rd_k);
          r.data     = s_rdata_i;
          resp_q.push_back(r);
          rd_pending = 1'b0;
        end else begin
          rd_delay--;
        end
      end
    end
    @(posedge clk); #1;
    mon_en = 1'b0;
    for (int k = 0; k < N; k++)
      chk("req_drained", 64'(exp_req[k].size()), 64'(0));
    chk("resp_drained", 64'(resp_q.size()), 64'(0));
    chk("no_read_left", 64'(rd_pending), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
